// File: rtl/dividor_seq_param.sv
// Sequential unsigned divider: integer quotient by restoring division, then
// FRAC_DIGITS truncated decimal fraction digits, one per cycle, fixed latency.
module dividor_seq_param #(
  parameter int SIZE        = 8,
  parameter int FRAC_DIGITS = 3,
  parameter int F_W         = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] m,
  output logic [F_W-1:0]  f,
  output logic            err,
  output logic            exact
);

  localparam int CNT_W = $clog2(SIZE + FRAC_DIGITS + 1);
  localparam int T_W   = SIZE + 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INT  = 2'd1;
  localparam logic [1:0] FRAC = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] FRAC_LAST = CNT_W'(FRAC_DIGITS - 1);
  localparam logic [T_W-1:0]   TEN_T     = T_W'(10);
  localparam logic [F_W-1:0]   TEN_F     = F_W'(10);

  logic [1:0]       state_reg;
  logic [SIZE-1:0]  b_reg;
  logic [SIZE-1:0]  q_reg;
  logic [SIZE-1:0]  rem_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [F_W-1:0]   facc_reg;
  logic [SIZE-1:0]  m_reg;
  logic [F_W-1:0]   f_reg;
  logic             err_reg;
  logic             exact_reg;
  logic             done_reg;

  // Integer phase: one restoring-division step, dividend bits shifted out of q_reg
  // while quotient bits shift in from the bottom.
  logic [SIZE:0]    rem_shift;
  logic             take_bit;
  logic [SIZE-1:0]  rem_int_next;
  logic [SIZE-1:0]  q_int_next;

  assign rem_shift    = {rem_reg, q_reg[SIZE-1]};
  assign take_bit     = (rem_shift >= {1'b0, b_reg});
  assign rem_int_next = take_bit ? SIZE'(rem_shift - {1'b0, b_reg}) : rem_shift[SIZE-1:0];
  assign q_int_next   = {q_reg[SIZE-2:0], take_bit};

  // Fraction phase: t = rem*10 is compared against all nine multiples of b in
  // parallel; the comparison results are monotonic, so the highest hit wins.
  logic [T_W-1:0]   t_val;
  logic [T_W-1:0]   mult [1:9];
  logic [9:1]       ge;
  logic [3:0]       digit;
  logic [SIZE-1:0]  rem_frac_next;
  logic [F_W-1:0]   facc_next;

  assign t_val = {4'd0, rem_reg} * TEN_T;

  generate
    for (genvar gi = 1; gi <= 9; gi++) begin : g_mult
      assign mult[gi] = {4'd0, b_reg} * T_W'(gi);
      assign ge[gi]   = (t_val >= mult[gi]);
    end
  endgenerate

  always_comb begin
    digit         = 4'd0;
    rem_frac_next = SIZE'(t_val);
    for (int k = 1; k <= 9; k++) begin
      if (ge[k]) begin
        digit         = 4'(k);
        rem_frac_next = SIZE'(t_val - mult[k]);
      end
    end
  end

  assign facc_next = F_W'(facc_reg * TEN_F) + F_W'(digit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      b_reg     <= '0;
      q_reg     <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      facc_reg  <= '0;
      m_reg     <= '0;
      f_reg     <= '0;
      err_reg   <= 1'b0;
      exact_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            b_reg     <= b;
            q_reg     <= a;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            facc_reg  <= '0;
            state_reg <= (b == '0) ? ERR : INT;
          end
        end
        ERR: begin
          m_reg     <= '0;
          f_reg     <= '0;
          err_reg   <= 1'b1;
          exact_reg <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        INT: begin
          rem_reg <= rem_int_next;
          q_reg   <= q_int_next;
          if (cnt_reg == INT_LAST) begin
            cnt_reg   <= '0;
            facc_reg  <= '0;
            state_reg <= FRAC;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        FRAC: begin
          rem_reg  <= rem_frac_next;
          facc_reg <= facc_next;
          if (cnt_reg == FRAC_LAST) begin
            m_reg     <= q_reg;
            f_reg     <= facc_next;
            err_reg   <= 1'b0;
            exact_reg <= (rem_frac_next == '0);
            done_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy  = (state_reg != IDLE);
  assign done  = done_reg;
  assign m     = m_reg;
  assign f     = f_reg;
  assign err   = err_reg;
  assign exact = exact_reg;

endmodule
